// File: rtl/simd_nested_loop_agen_pkg.sv
// -----------------------------------------------------------------------------
// simd_pkg
// Shared definitions for the SIMD nested-loop address generator:
//   - cfg_kind encodings for the configuration write port
//   - FSM state type of the generator
// -----------------------------------------------------------------------------
package simd_pkg;

  localparam logic [1:0] CFG_BASE   = 2'd0;
  localparam logic [1:0] CFG_STRIDE = 2'd1;
  localparam logic [1:0] CFG_ITERS  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/simd_nested_loop_agen_loop_level_ctr.sv
// -----------------------------------------------------------------------------
// simd_loop_level_ctr
// Index counter for one level of the loop nest.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   iters      : iteration count of this level (0 behaves as 1)
//   inc        : advance this level (wraps to 0 when at the last index)
//   clear      : force the index to 0 (launch of a new nest)
//   at_last    : index equals the last index of this level
//   idx        : current index
// -----------------------------------------------------------------------------
module simd_loop_level_ctr #(
  parameter int ITER_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ITER_WIDTH-1:0] iters,
  input  logic                  inc,
  input  logic                  clear,
  output logic                  at_last,
  output logic [ITER_WIDTH-1:0] idx
);

  logic [ITER_WIDTH-1:0] r_idx;
  logic [ITER_WIDTH-1:0] w_last_idx;

  // A zero count is a single-iteration level, so its last index is 0.
  assign w_last_idx = (iters == '0) ? '0 : iters - ITER_WIDTH'(1);
  assign at_last    = (r_idx == w_last_idx);
  assign idx        = r_idx;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_idx <= '0;
    end else if (inc) begin
      r_idx <= at_last ? '0 : r_idx + ITER_WIDTH'(1);
    end
  end

endmodule

// File: rtl/simd_nested_loop_agen.sv
// -----------------------------------------------------------------------------
// simd_nested_loop_agen
// Nested-loop, multi-namespace address generator for the SIMD lane.
// addr[n] = base[n] + sum_l idx[l]*stride[n][l] (mod 2^ADDRESS_WIDTH), produced
// incrementally (no multipliers), one vector per accepted valid/ready beat.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   cfg_valid/kind/ns/level/data : configuration write (IDLE/DONE only)
//   start               : launch the programmed nest (IDLE only)
//   busy                : high while running
//   out_valid/out_ready : output handshake
//   out_addr            : channel n at [n*ADDRESS_WIDTH +: ADDRESS_WIDTH]
//   out_wrap            : bit l set when level l is at its last index
//   out_last            : final vector of the nest
//   done                : one-cycle pulse after the final beat is accepted
//   perf_stall_cycles   : only with SIMD_AGEN_PERF_CNT_EN defined; saturating
//                         count of RUN cycles with out_valid && !out_ready
// Build option: define SIMD_AGEN_PERF_CNT_EN to add the stall counter.
// -----------------------------------------------------------------------------
module simd_nested_loop_agen
  import simd_pkg::*;
#(
  parameter int NUM_LOOPS      = 4,
  parameter int NUM_NS         = 3,
  parameter int ADDRESS_WIDTH  = 32,
  parameter int STRIDE_WIDTH   = 32,
  parameter int ITER_WIDTH     = 16,
  parameter int CFG_DATA_WIDTH = 32,
  localparam int NSW = (NUM_NS > 1) ? $clog2(NUM_NS) : 1,
  localparam int LVW = (NUM_LOOPS > 1) ? $clog2(NUM_LOOPS) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            cfg_valid,
  input  logic [1:0]                      cfg_kind,
  input  logic [NSW-1:0]                  cfg_ns,
  input  logic [LVW-1:0]                  cfg_level,
  input  logic [CFG_DATA_WIDTH-1:0]       cfg_data,
  input  logic                            start,
  output logic                            busy,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_NS*ADDRESS_WIDTH-1:0] out_addr,
  output logic [NUM_LOOPS-1:0]            out_wrap,
  output logic                            out_last,
  output logic                            done
`ifdef SIMD_AGEN_PERF_CNT_EN
  ,
  output logic [31:0]                     perf_stall_cycles
`endif
);

  localparam int AW = ADDRESS_WIDTH;
  localparam int SW = STRIDE_WIDTH;
  localparam int IW = ITER_WIDTH;
  localparam int CW = CFG_DATA_WIDTH;

  function automatic logic [AW-1:0] fit_addr(input logic [CW-1:0] d);
    return AW'($signed(d));
  endfunction

  function automatic logic [SW-1:0] fit_stride(input logic [CW-1:0] d);
    return SW'($signed(d));
  endfunction

  function automatic logic [IW-1:0] fit_iters(input logic [CW-1:0] d);
    return IW'($signed(d));
  endfunction

  function automatic logic [AW-1:0] stride_to_addr(input logic [SW-1:0] s);
    return AW'($signed(s));
  endfunction

  state_t          r_state;
  logic [AW-1:0]   r_base   [NUM_NS];
  logic [SW-1:0]   r_stride [NUM_NS][NUM_LOOPS];
  logic [IW-1:0]   r_iters  [NUM_LOOPS];
  logic [AW-1:0]   r_addr   [NUM_NS];
  // Per-level accumulated offset idx[l]*stride[n][l], kept so a wrapping level
  // can be unwound with a subtraction instead of a multiply.
  logic [AW-1:0]   r_off    [NUM_NS][NUM_LOOPS];

  logic                 w_cfg_ok;
  logic                 w_launch;
  logic                 w_beat;
  logic                 w_last;
  logic [NUM_LOOPS-1:0] w_inc;
  logic [NUM_LOOPS-1:0] w_at_last;
  logic [IW-1:0]        w_idx    [NUM_LOOPS];
  logic [AW-1:0]        w_base_eff [NUM_NS];
  logic [AW-1:0]        w_delta  [NUM_NS];

  assign w_cfg_ok = (r_state != RUN);
  assign w_launch = (r_state == IDLE) && start;
  assign w_beat   = (r_state == RUN) && out_ready;
  assign w_last   = &w_at_last;

  assign busy      = (r_state == RUN);
  assign out_valid = (r_state == RUN);
  assign done      = (r_state == DONE);
  assign out_wrap  = out_valid ? w_at_last : '0;
  assign out_last  = out_valid && w_last;

  // Configuration registers
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < NUM_NS; n++) begin
        r_base[n] <= '0;
        for (int l = 0; l < NUM_LOOPS; l++) r_stride[n][l] <= '0;
      end
      for (int l = 0; l < NUM_LOOPS; l++) r_iters[l] <= IW'(1);
    end else if (cfg_valid && w_cfg_ok) begin
      case (cfg_kind)
        CFG_BASE: begin
          if (int'(cfg_ns) < NUM_NS) r_base[cfg_ns] <= fit_addr(cfg_data);
        end
        CFG_STRIDE: begin
          if (int'(cfg_ns) < NUM_NS && int'(cfg_level) < NUM_LOOPS)
            r_stride[cfg_ns][cfg_level] <= fit_stride(cfg_data);
        end
        CFG_ITERS: begin
          if (int'(cfg_level) < NUM_LOOPS) r_iters[cfg_level] <= fit_iters(cfg_data);
        end
        default: ;
      endcase
    end
  end

  // Control FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE:    if (start) r_state <= RUN;
        RUN:     if (w_beat && w_last) r_state <= DONE;
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Level counters: a level advances only when every lower level wraps.
  // The final beat advances nothing; the next launch clears all indices.
  genvar gl;
  generate
    for (gl = 0; gl < NUM_LOOPS; gl++) begin : g_level
      if (gl == 0) begin : g_first
        assign w_inc[gl] = w_beat && !w_last;
      end else begin : g_chain
        assign w_inc[gl] = w_inc[gl-1] && w_at_last[gl-1];
      end

      simd_loop_level_ctr #(
        .ITER_WIDTH(IW)
      ) u_ctr (
        .clk    (clk),
        .reset  (reset),
        .iters  (r_iters[gl]),
        .inc    (w_inc[gl]),
        .clear  (w_launch),
        .at_last(w_at_last[gl]),
        .idx    (w_idx[gl])
      );
    end
  endgenerate

  // Address step: wrapping levels subtract their offset, the level that
  // advances adds its stride, higher levels contribute nothing.
  always_comb begin
    for (int n = 0; n < NUM_NS; n++) begin
      w_delta[n] = '0;
      for (int l = 0; l < NUM_LOOPS; l++) begin
        if (w_inc[l]) begin
          w_delta[n] = w_at_last[l] ? w_delta[n] - r_off[n][l]
                                    : w_delta[n] + stride_to_addr(r_stride[n][l]);
        end
      end
    end
  end

  genvar gn;
  generate
    for (gn = 0; gn < NUM_NS; gn++) begin : g_ns
      // A base write in the launch cycle must already be visible in vector 0.
      assign w_base_eff[gn] = (cfg_valid && (cfg_kind == CFG_BASE) && (int'(cfg_ns) == gn))
                              ? fit_addr(cfg_data) : r_base[gn];

      assign out_addr[gn*AW +: AW] = r_addr[gn];

      always_ff @(posedge clk) begin
        if (reset) begin
          r_addr[gn] <= '0;
        end else if (w_launch) begin
          r_addr[gn] <= w_base_eff[gn];
        end else if (w_inc[0]) begin
          r_addr[gn] <= r_addr[gn] + w_delta[gn];
        end
      end

      always_ff @(posedge clk) begin
        for (int l = 0; l < NUM_LOOPS; l++) begin
          if (w_launch) begin
            r_off[gn][l] <= '0;
          end else if (w_inc[l]) begin
            r_off[gn][l] <= w_at_last[l] ? '0
                                         : r_off[gn][l] + stride_to_addr(r_stride[gn][l]);
          end
        end
      end
    end
  endgenerate

`ifdef SIMD_AGEN_PERF_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (reset || w_launch) begin
      r_stall_cnt <= '0;
    end else if ((r_state == RUN) && !out_ready && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign perf_stall_cycles = r_stall_cnt;
`endif

  // The per-level index values are only needed for the at_last decode.
  logic w_unused_idx;
  always_comb begin
    w_unused_idx = 1'b0;
    for (int l = 0; l < NUM_LOOPS; l++) w_unused_idx = w_unused_idx ^ (^w_idx[l]);
  end

endmodule

// File: tb/tb_simd_nested_loop_agen.sv
module tb_simd_nested_loop_agen;

  localparam logic [1:0] K_BASE   = 2'd0;
  localparam logic [1:0] K_STRIDE = 2'd1;
  localparam logic [1:0] K_ITERS  = 2'd2;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_valid;
  logic [1:0]  cfg_kind;
  logic [1:0]  cfg_ns;
  logic [1:0]  cfg_level;
  logic [31:0] cfg_data;
  logic        start;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [95:0] out_addr;
  logic [3:0]  out_wrap;
  logic        out_last;
  logic        done;
`ifdef SIMD_AGEN_PERF_CNT_EN
  logic [31:0] perf_stall_cycles;
`endif

  always #5 clk = ~clk;

  simd_nested_loop_agen dut (
    .clk      (clk),
    .reset    (reset),
    .cfg_valid(cfg_valid),
    .cfg_kind (cfg_kind),
    .cfg_ns   (cfg_ns),
    .cfg_level(cfg_level),
    .cfg_data (cfg_data),
    .start    (start),
    .busy     (busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_addr (out_addr),
    .out_wrap (out_wrap),
    .out_last (out_last),
    .done     (done)
`ifdef SIMD_AGEN_PERF_CNT_EN
    ,
    .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  int checks = 0;
  int fails  = 0;

  // Reference configuration as seen by the programmer.
  logic [31:0] m_base   [3];
  logic [31:0] m_stride [3][4];
  logic [15:0] m_iters  [4];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < 3; n++) begin
      m_base[n] = '0;
      for (int l = 0; l < 4; l++) m_stride[n][l] = '0;
    end
    for (int l = 0; l < 4; l++) m_iters[l] = 16'd1;
  endtask

  function automatic int eff(input int l);
    return (m_iters[l] == 16'd0) ? 1 : int'(m_iters[l]);
  endfunction

  function automatic int total();
    int p = 1;
    for (int l = 0; l < 4; l++) p = p * eff(l);
    return p;
  endfunction

  // Mixed-radix decomposition of the beat number, level 0 fastest.
  function automatic int idx_at(input int k, input int l);
    int rem = k;
    for (int j = 0; j < l; j++) rem = rem / eff(j);
    return rem % eff(l);
  endfunction

  function automatic logic [95:0] exp_vec(input int k);
    logic [95:0] v;
    logic [31:0] a;
    for (int n = 0; n < 3; n++) begin
      a = m_base[n];
      for (int l = 0; l < 4; l++) a = a + 32'(idx_at(k, l)) * m_stride[n][l];
      v[n*32 +: 32] = a;
    end
    return v;
  endfunction

  function automatic logic [3:0] exp_wrap(input int k);
    logic [3:0] w;
    for (int l = 0; l < 4; l++) w[l] = (idx_at(k, l) == eff(l) - 1);
    return w;
  endfunction

  task automatic cfg(input logic [1:0] kind, input int ns, input int level, input logic [31:0] data);
    cfg_valid = 1'b1;
    cfg_kind  = kind;
    cfg_ns    = 2'(ns);
    cfg_level = 2'(level);
    cfg_data  = data;
    case (kind)
      K_BASE:   m_base[ns] = data;
      K_STRIDE: m_stride[ns][level] = data;
      K_ITERS:  m_iters[level] = data[15:0];
      default: ;
    endcase
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // mode 0: ready always 1; 1: random ready; 2: five stall cycles at beat 2.
  task automatic run(input int mode, input bit inject, input bit abort,
                     input bit co_cfg, input logic [31:0] co_data);
    int  k = 0;
    int  tot;
    int  cyc = 0;
    int  stalls = 0;
    int  stall_left = 5;
    bit  rdy;
    if (co_cfg) begin
      cfg_valid = 1'b1; cfg_kind = K_BASE; cfg_ns = 2'd0; cfg_level = 2'd0; cfg_data = co_data;
      m_base[0] = co_data;
    end
    tot = total();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cfg_valid = 1'b0;
    while (k < tot) begin
      if (cyc > 8 * tot + 50) begin
        checks++;
        fails++;
        $error("FAIL timeout: observed beat %0d expected beat %0d", k, tot);
        break;
      end
      chk("valid", out_valid, 1);
      chk("busy", busy, 1);
      chk("addr", out_addr, exp_vec(k));
      chk("wrap", out_wrap, exp_wrap(k));
      chk("last", out_last, k == tot - 1);
      if (abort && k == 2) begin
        reset = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addr", out_addr, 0);
        chk("rst_wrap", out_wrap, 0);
        chk("rst_last", out_last, 0);
        chk("rst_done", done, 0);
        reset = 1'b0;
        model_reset();
        return;
      end
      if (mode == 0) rdy = 1'b1;
      else if (mode == 1) rdy = 1'($urandom_range(0, 1));
      else begin
        rdy = !(k == 2 && stall_left > 0);
        if (!rdy) stall_left--;
      end
      out_ready = rdy;
      if (!rdy) stalls++;
      if (inject && k == 1) begin
        cfg_valid = 1'b1; cfg_kind = K_STRIDE; cfg_ns = 2'd0; cfg_level = 2'd0;
        cfg_data = $urandom | 32'h1;
        start = 1'b1;
      end
      @(negedge clk);
      cfg_valid = 1'b0;
      start = 1'b0;
      cyc++;
      if (rdy) k++;
    end
    chk("done_pulse", done, 1);
    chk("valid_after", out_valid, 0);
    chk("busy_after", busy, 0);
`ifdef SIMD_AGEN_PERF_CNT_EN
    chk("perf_stall", perf_stall_cycles, 32'(stalls));
`endif
    @(negedge clk);
    chk("done_once", done, 0);
    out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cfg_valid = 1'b0; cfg_kind = '0; cfg_ns = '0; cfg_level = '0;
    cfg_data = '0; start = 1'b0; out_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_valid", out_valid, 0);
    chk("reset_addr", out_addr, 0);
    chk("reset_wrap", out_wrap, 0);
    chk("reset_last", out_last, 0);
    chk("reset_done", done, 0);
    reset = 1'b0;
    @(negedge clk);

    // Single level, 0x100 step 8.
    cfg(K_ITERS, 0, 0, 32'd4);
    cfg(K_BASE, 0, 0, 32'h100);
    cfg(K_STRIDE, 0, 0, 32'd8);
    run(0, 0, 0, 0, '0);

    // Two levels, two channels, negative stride.
    do_reset();
    cfg(K_ITERS, 0, 0, 32'd3);
    cfg(K_ITERS, 0, 1, 32'd2);
    cfg(K_STRIDE, 0, 0, 32'd1);
    cfg(K_STRIDE, 0, 1, 32'd16);
    cfg(K_STRIDE, 1, 0, 32'hFFFF_FFFF);
    cfg(K_BASE, 1, 0, 32'd10);
    run(0, 0, 0, 0, '0);

    // Backpressure window.
    run(2, 0, 0, 0, '0);

    // Zero count and address wrap-around.
    do_reset();
    cfg(K_ITERS, 0, 0, 32'd0);
    run(0, 0, 0, 0, '0);
    cfg(K_BASE, 0, 0, 32'hFFFF_FFFC);
    cfg(K_STRIDE, 0, 0, 32'd4);
    cfg(K_ITERS, 0, 0, 32'd2);
    run(0, 0, 0, 0, '0);

    // Reset on beat 3 of 8, then a default run.
    do_reset();
    cfg(K_ITERS, 0, 0, 32'd2);
    cfg(K_ITERS, 0, 1, 32'd2);
    cfg(K_ITERS, 0, 2, 32'd2);
    cfg(K_STRIDE, 2, 1, 32'h40);
    run(0, 0, 1, 0, '0);
    @(negedge clk);
    run(0, 0, 0, 0, '0);

    // Writes and start during RUN are dropped; the next run sees old stride.
    do_reset();
    cfg(K_ITERS, 0, 0, 32'd3);
    cfg(K_ITERS, 0, 1, 32'd2);
    cfg(K_STRIDE, 0, 0, 32'd5);
    cfg(K_STRIDE, 0, 1, 32'd100);
    run(1, 1, 0, 0, '0);
    run(0, 0, 0, 0, '0);

    // Base write coincident with start is used by the run.
    run(0, 0, 0, 1, 32'h0000_8000);

    // Randomised nests.
    for (int r = 0; r < 8; r++) begin
      do_reset();
      for (int l = 0; l < 4; l++) cfg(K_ITERS, 0, l, {16'($urandom), 16'($urandom_range(0, 3))});
      for (int n = 0; n < 3; n++) begin
        cfg(K_BASE, n, 0, $urandom);
        for (int l = 0; l < 4; l++) cfg(K_STRIDE, n, l, $urandom);
      end
      run(1, 0, 0, 0, '0);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
